// File: rtl/mem_req_ctrl.sv
// Single-outstanding load/store initiator toward the cache memory system.
// Holds one request stable until Done, stalls the pipeline, counts requests/hits and latches errors.
module mem_req_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_rd,
  input  logic              pipe_wr,
  input  logic [15:0]       pipe_addr,
  input  logic [15:0]       pipe_wdata,
  output logic              pipe_stall,
  output logic [15:0]       pipe_rdata,
  output logic              pipe_valid,
  output logic [15:0]       mem_addr,
  output logic [15:0]       mem_datain,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [15:0]       mem_dataout,
  input  logic              mem_done,
  input  logic              mem_stall,
  input  logic              mem_cachehit,
  input  logic              mem_err,
  output logic              err,
  output logic [CNT_W-1:0]  req_cnt,
  output logic [CNT_W-1:0]  hit_cnt
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ERR  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [15:0]       mem_addr_q, mem_addr_d;
  logic [15:0]       mem_datain_q, mem_datain_d;
  logic              mem_rd_q, mem_rd_d;
  logic              mem_wr_q, mem_wr_d;
  logic [15:0]       pipe_rdata_q, pipe_rdata_d;
  logic              pipe_valid_q, pipe_valid_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
  logic              req_s;
  logic              illegal_s;
  logic              mem_stall_unused_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_W'(1);
    end
  endfunction

  // Memory-side Stall is informational; control relies on Done alone.
  assign mem_stall_unused_s = mem_stall;

  // The old request is still presented during the pipe_valid cycle, so it must not re-issue.
  assign req_s     = (pipe_rd | pipe_wr) & ~pipe_valid_q;
  assign illegal_s = (pipe_rd & pipe_wr) | pipe_addr[0];

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    mem_addr_d   = mem_addr_q;
    mem_datain_d = mem_datain_q;
    mem_rd_d     = mem_rd_q;
    mem_wr_d     = mem_wr_q;
    pipe_rdata_d = pipe_rdata_q;
    pipe_valid_d = 1'b0;
    err_d        = err_q;
    req_cnt_d    = req_cnt_q;
    hit_cnt_d    = hit_cnt_q;

    if (mem_err) begin
      state_d  = ERR;
      err_d    = 1'b1;
      mem_rd_d = 1'b0;
      mem_wr_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_s && illegal_s) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else if (req_s) begin
            state_d      = BUSY;
            tmo_d        = '0;
            mem_addr_d   = pipe_addr;
            mem_datain_d = pipe_wdata;
            mem_rd_d     = pipe_rd;
            mem_wr_d     = pipe_wr;
          end else begin
            state_d = IDLE;
          end
        end
        BUSY: begin
          if (mem_done) begin
            state_d      = IDLE;
            mem_rd_d     = 1'b0;
            mem_wr_d     = 1'b0;
            pipe_valid_d = 1'b1;
            req_cnt_d    = sat_inc(req_cnt_q);
            if (mem_rd_q) begin
              pipe_rdata_d = mem_dataout;
            end else begin
              pipe_rdata_d = pipe_rdata_q;
            end
            if (mem_cachehit) begin
              hit_cnt_d = sat_inc(hit_cnt_q);
            end else begin
              hit_cnt_d = hit_cnt_q;
            end
          end else if (tmo_q == TMO_LAST) begin
            state_d  = ERR;
            err_d    = 1'b1;
            mem_rd_d = 1'b0;
            mem_wr_d = 1'b0;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        ERR: begin
          state_d  = ERR;
          err_d    = 1'b1;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
        end
        default: begin
          state_d  = ERR;
          err_d    = 1'b1;
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      tmo_q        <= '0;
      mem_addr_q   <= 16'h0000;
      mem_datain_q <= 16'h0000;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      pipe_rdata_q <= 16'h0000;
      pipe_valid_q <= 1'b0;
      err_q        <= 1'b0;
      req_cnt_q    <= '0;
      hit_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      tmo_q        <= tmo_d;
      mem_addr_q   <= mem_addr_d;
      mem_datain_q <= mem_datain_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      pipe_rdata_q <= pipe_rdata_d;
      pipe_valid_q <= pipe_valid_d;
      err_q        <= err_d;
      req_cnt_q    <= req_cnt_d;
      hit_cnt_q    <= hit_cnt_d;
    end
  end

  assign pipe_stall = ((state_q == IDLE) & req_s) | (state_q == BUSY) | (state_q == ERR);
  assign pipe_rdata = pipe_rdata_q;
  assign pipe_valid = pipe_valid_q;
  assign mem_addr   = mem_addr_q;
  assign mem_datain = mem_datain_q;
  assign mem_rd     = mem_rd_q;
  assign mem_wr     = mem_wr_q;
  assign err        = err_q;
  assign req_cnt    = req_cnt_q;
  assign hit_cnt    = hit_cnt_q;

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Randomized self-checking bench for mem_req_ctrl with a transaction-level memory/pipeline model.
// Small TIMEOUT and CNT_W keep timeout and counter saturation reachable.
module tb_mem_req_ctrl;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic clk, rst;
  logic pipe_rd, pipe_wr;
  logic [15:0] pipe_addr, pipe_wdata, pipe_rdata;
  logic pipe_stall, pipe_valid;
  logic [15:0] mem_addr, mem_datain, mem_dataout;
  logic mem_rd, mem_wr, mem_done, mem_stall, mem_cachehit, mem_err, err;
  logic [CNT_W-1:0] req_cnt, hit_cnt;

  int n_chk = 0;
  int n_fail = 0;
  int m_req, m_hit;
  logic [15:0] m_rdata;

  mem_req_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .pipe_rd(pipe_rd), .pipe_wr(pipe_wr), .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata),
    .pipe_stall(pipe_stall), .pipe_rdata(pipe_rdata), .pipe_valid(pipe_valid),
    .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_dataout(mem_dataout), .mem_done(mem_done), .mem_stall(mem_stall),
    .mem_cachehit(mem_cachehit), .mem_err(mem_err), .err(err),
    .req_cnt(req_cnt), .hit_cnt(hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    pipe_rd = 1'b0; pipe_wr = 1'b0; pipe_addr = 16'h0000; pipe_wdata = 16'h0000;
    mem_dataout = 16'h0000; mem_done = 1'b0; mem_stall = 1'b0; mem_cachehit = 1'b0; mem_err = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_req = 0; m_hit = 0; m_rdata = 16'h0000;
  endtask

  // One complete legal transaction; entered and left just after a falling edge.
  task automatic run_txn(input bit rd, input bit wr, input logic [15:0] addr, input logic [15:0] wdata,
                         input int lat, input logic [15:0] dout, input bit hit, input bit hold);
    pipe_rd = rd; pipe_wr = wr; pipe_addr = addr; pipe_wdata = wdata;
    #1;
    n_chk++;
    if (pipe_stall !== 1'b1) begin
      n_fail++; $display("FAIL req_stall: got %b want 1", pipe_stall);
    end
    @(negedge clk);
    for (int k = 1; k <= lat; k++) begin
      n_chk++;
      if ({mem_rd, mem_wr, mem_addr, mem_datain, pipe_stall, pipe_valid, err} !==
          {rd, wr, addr, wdata, 1'b1, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL busy_hold cyc %0d: rd=%b wr=%b addr=%h din=%h stall=%b valid=%b err=%b want rd=%b wr=%b addr=%h din=%h stall=1 valid=0 err=0",
                 k, mem_rd, mem_wr, mem_addr, mem_datain, pipe_stall, pipe_valid, err, rd, wr, addr, wdata);
      end
      mem_stall = 1'($urandom_range(1, 0));
      if (k == lat) begin
        mem_done = 1'b1; mem_dataout = dout; mem_cachehit = hit;
      end else begin
        mem_done = 1'b0; mem_dataout = 16'($urandom); mem_cachehit = 1'($urandom_range(1, 0));
      end
      @(negedge clk);
    end
    mem_done = 1'b0; mem_cachehit = 1'b0; mem_stall = 1'b0;
    m_req = (m_req < CMAX) ? m_req + 1 : CMAX;
    if (hit) m_hit = (m_hit < CMAX) ? m_hit + 1 : CMAX;
    if (rd) m_rdata = dout;
    n_chk++;
    if ({pipe_valid, pipe_rdata, req_cnt, hit_cnt, mem_rd, mem_wr, pipe_stall} !==
        {1'b1, m_rdata, m_req[CNT_W-1:0], m_hit[CNT_W-1:0], 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL complete: valid=%b rdata=%h req=%0d hit=%0d rd=%b wr=%b stall=%b want valid=1 rdata=%h req=%0d hit=%0d rd=0 wr=0 stall=0",
               pipe_valid, pipe_rdata, req_cnt, hit_cnt, mem_rd, mem_wr, pipe_stall, m_rdata, m_req, m_hit);
    end
    @(negedge clk);
    n_chk++;
    if ({pipe_valid, mem_rd, mem_wr} !== 3'b000) begin
      n_fail++; $display("FAIL no_dup: valid=%b rd=%b wr=%b want 000", pipe_valid, mem_rd, mem_wr);
    end
    if (!hold) begin
      pipe_rd = 1'b0; pipe_wr = 1'b0;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    m_req = 0; m_hit = 0; m_rdata = 16'h0000;
    @(negedge clk);
    n_chk++;
    if ({mem_rd, mem_wr, pipe_valid, err, mem_addr, mem_datain, pipe_rdata, req_cnt, hit_cnt, pipe_stall} !== '0) begin
      n_fail++;
      $display("FAIL reset_vals: rd=%b wr=%b valid=%b err=%b addr=%h din=%h rdata=%h req=%0d hit=%0d stall=%b want all 0",
               mem_rd, mem_wr, pipe_valid, err, mem_addr, mem_datain, pipe_rdata, req_cnt, hit_cnt, pipe_stall);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_hit();
    run_txn(1'b1, 1'b0, 16'h0010, 16'h0000, 2, 16'hBEEF, 1'b1, 1'b0);
  endtask

  task automatic test_write_miss();
    run_txn(1'b0, 1'b1, 16'h0402, 16'h1234, 5, 16'h5555, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_txn(1'b1, 1'b0, 16'h0100, 16'h0000, 3, 16'hA001, 1'b0, 1'b1);
    run_txn(1'b1, 1'b0, 16'h0102, 16'h0000, 1, 16'hA002, 1'b1, 1'b1);
    run_txn(1'b0, 1'b1, 16'h0104, 16'h7777, 4, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_spurious_done();
    mem_done = 1'b1; mem_cachehit = 1'b1; mem_dataout = 16'hDEAD;
    @(negedge clk);
    mem_done = 1'b0; mem_cachehit = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({pipe_valid, mem_rd, req_cnt, hit_cnt, pipe_rdata} !== {2'b00, m_req[CNT_W-1:0], m_hit[CNT_W-1:0], m_rdata}) begin
      n_fail++;
      $display("FAIL spurious_done: valid=%b rd=%b req=%0d hit=%0d rdata=%h want 0 0 %0d %0d %h",
               pipe_valid, mem_rd, req_cnt, hit_cnt, pipe_rdata, m_req, m_hit, m_rdata);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int t = 0; t < 24; t++) begin
      bit rd;
      rd = 1'($urandom_range(1, 0));
      run_txn(rd, ~rd, 16'($urandom) & 16'hFFFE, 16'($urandom), int'($urandom_range(TIMEOUT, 1)),
              16'($urandom), 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
    end
    pipe_rd = 1'b0; pipe_wr = 1'b0;
  endtask

  task automatic test_illegal(input bit rd, input bit wr, input logic [15:0] addr);
    apply_reset();
    pipe_rd = rd; pipe_wr = wr; pipe_addr = addr; pipe_wdata = 16'hFFFF;
    @(negedge clk);
    pipe_rd = 1'b0; pipe_wr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_chk++;
      if ({err, mem_rd, mem_wr, pipe_stall} !== 4'b1001) begin
        n_fail++;
        $display("FAIL illegal rd=%b wr=%b addr=%h: err=%b mrd=%b mwr=%b stall=%b want 1 0 0 1",
                 rd, wr, addr, err, mem_rd, mem_wr, pipe_stall);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    apply_reset();
    run_txn(1'b0, 1'b1, 16'h0020, 16'h0BAD, 1, 16'h0000, 1'b1, 1'b0);
    pipe_rd = 1'b1; pipe_addr = 16'h0030;
    @(negedge clk);
    for (int k = 1; k <= TIMEOUT; k++) begin
      n_chk++;
      if ({mem_rd, err} !== 2'b10) begin
        n_fail++; $display("FAIL timeout_wait cyc %0d: rd=%b err=%b want 1 0", k, mem_rd, err);
      end
      @(negedge clk);
    end
    pipe_rd = 1'b0;
    mem_done = 1'b1; mem_cachehit = 1'b1;
    #1;
    n_chk++;
    if ({err, mem_rd, pipe_stall, req_cnt, hit_cnt} !== {3'b101, m_req[CNT_W-1:0], m_hit[CNT_W-1:0]}) begin
      n_fail++;
      $display("FAIL timeout_err: err=%b rd=%b stall=%b req=%0d hit=%0d want 1 0 1 %0d %0d",
               err, mem_rd, pipe_stall, req_cnt, hit_cnt, m_req, m_hit);
    end
    @(negedge clk);
    mem_done = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({err, pipe_valid, pipe_stall, req_cnt} !== {3'b101, m_req[CNT_W-1:0]}) begin
      n_fail++;
      $display("FAIL err_sticky: err=%b valid=%b stall=%b req=%0d want 1 0 1 %0d", err, pipe_valid, pipe_stall, req_cnt, m_req);
    end
  endtask

  task automatic test_err_with_done();
    apply_reset();
    run_txn(1'b1, 1'b0, 16'h0040, 16'h0000, 2, 16'h4242, 1'b1, 1'b0);
    pipe_rd = 1'b1; pipe_addr = 16'h0042;
    @(negedge clk);
    @(negedge clk);
    mem_done = 1'b1; mem_err = 1'b1; mem_cachehit = 1'b1; mem_dataout = 16'h9999;
    @(negedge clk);
    clear_inputs();
    n_chk++;
    if ({err, pipe_valid, mem_rd, pipe_stall, req_cnt, hit_cnt, pipe_rdata} !==
        {4'b1001, m_req[CNT_W-1:0], m_hit[CNT_W-1:0], m_rdata}) begin
      n_fail++;
      $display("FAIL err_with_done: err=%b valid=%b rd=%b stall=%b req=%0d hit=%0d rdata=%h want 1 0 0 1 %0d %0d %h",
               err, pipe_valid, mem_rd, pipe_stall, req_cnt, hit_cnt, pipe_rdata, m_req, m_hit, m_rdata);
    end
  endtask

  task automatic test_reset_mid_busy();
    apply_reset();
    run_txn(1'b1, 1'b0, 16'h0050, 16'h0000, 1, 16'h1111, 1'b1, 1'b0);
    pipe_rd = 1'b1; pipe_addr = 16'h0052;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1; pipe_rd = 1'b0;
    #1;
    m_req = 0; m_hit = 0; m_rdata = 16'h0000;
    n_chk++;
    if ({mem_rd, pipe_stall, err, pipe_valid, req_cnt, hit_cnt, pipe_rdata} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: rd=%b stall=%b err=%b valid=%b req=%0d hit=%0d rdata=%h want all 0",
               mem_rd, pipe_stall, err, pipe_valid, req_cnt, hit_cnt, pipe_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_txn(1'b1, 1'b0, 16'h0060, 16'h0000, 3, 16'hC0DE, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_write_miss();
    test_back_to_back();
    test_spurious_done();
    test_random();
    test_illegal(1'b1, 1'b0, 16'h0003);
    test_illegal(1'b1, 1'b1, 16'h0010);
    test_timeout();
    test_err_with_done();
    test_reset_mid_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
